// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Brief    : 640x480 raster timing generator. Produces pixel coordinates,
//             the visible-area flag, line/frame pulses, a frame counter and
//             monitor sync pulses delayed to match registered colour output.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       pixel_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Sync windows are compared as int so an end value of 1024 cannot wrap.
    localparam int c_hs_start = H_ACTIVE + H_FP;
    localparam int c_hs_end   = H_ACTIVE + H_FP + H_SYNC;
    localparam int c_vs_start = V_ACTIVE + V_FP;
    localparam int c_vs_end   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [9:0] c_h_last = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last = 10'(c_v_total - 1);

    // Counters are 10 bits wide and the delay line is at most 4 stages deep.
    generate
        if (c_h_total > 1024 || c_v_total > 1024 || SYNC_DELAY > 4 || SYNC_DELAY < 0) begin : g_param_check
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and SYNC_DELAY in 0..4");
        end
    endgenerate

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       r_line_start;
    logic       r_frame_start;
    logic [7:0] r_frame_count;

    logic w_h_last;
    logic w_v_last;
    logic w_hs_raw;
    logic w_vs_raw;

    assign w_h_last = (r_hc == c_h_last);
    assign w_v_last = (r_vc == c_v_last);

    // Raw active-low sync decode of the current position.
    assign w_hs_raw = !((int'(r_hc) >= c_hs_start) && (int'(r_hc) < c_hs_end));
    assign w_vs_raw = !((int'(r_vc) >= c_vs_start) && (int'(r_vc) < c_vs_end));

    // Visible flag is decoded from the live counters so it lines up with DrawX/DrawY.
    assign blank = (int'(r_hc) < H_ACTIVE) && (int'(r_vc) < V_ACTIVE);

    // Horizontal/vertical raster counters, advancing one pixel per enabled step.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (pixel_ce) begin
            if (w_h_last) begin
                r_hc <= '0;
                r_vc <= w_v_last ? 10'd0 : r_vc + 10'd1;
            end else begin
                r_hc <= r_hc + 10'd1;
            end
        end
    end

    // Wrap pulses last one vga_clk cycle even when pixel_ce is low afterwards.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_line_start  <= pixel_ce && w_h_last;
            r_frame_start <= pixel_ce && w_h_last && w_v_last;
            if (pixel_ce && w_h_last && w_v_last) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hs = w_hs_raw;
            assign vs = w_vs_raw;
        end else begin : g_delay
            logic r_hs_pipe [SYNC_DELAY];
            logic r_vs_pipe [SYNC_DELAY];

            // Sync delay line, stepping only on pixel_ce so the lag is counted in pixels.
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        r_hs_pipe[i] <= 1'b1;
                        r_vs_pipe[i] <= 1'b1;
                    end
                end else if (pixel_ce) begin
                    r_hs_pipe[0] <= w_hs_raw;
                    r_vs_pipe[0] <= w_vs_raw;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        r_hs_pipe[i] <= r_hs_pipe[i-1];
                        r_vs_pipe[i] <= r_vs_pipe[i-1];
                    end
                end
            end

            assign hs = r_hs_pipe[SYNC_DELAY-1];
            assign vs = r_vs_pipe[SYNC_DELAY-1];
        end
    endgenerate

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Brief    : Self-checking bench for vga_timing_gen using a reduced raster
//             (20x12 total) so that 256 full frames fit in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HA = 12;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 20
    localparam int VT = VA + VF + VS + VB;   // 12
    localparam int FT = HT * VT;             // 240

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       bl;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } vec_t;

    localparam vec_t RESET_VEC = '{x: 10'd0, y: 10'd0, bl: 1'b1, hs: 1'b1, vs: 1'b1,
                                   ls: 1'b0, fs: 1'b0, fc: 8'd0};

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic       pixel_ce;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_DELAY(1)
    ) dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .pixel_ce   (pixel_ce),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .hs         (hs),
        .vs         (vs),
        .line_start (line_start),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 vga_clk = ~vga_clk;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t sb_q[$];

    // Reference model state
    int         m_x, m_y;
    logic       m_hs, m_vs, m_ls, m_fs;
    logic [7:0] m_fc;

    // Sync measurements taken from the DUT outputs
    int   hs_low, hs_first_x, vs_low, vs_first_x, vs_first_y;
    logic hs_prev, vs_prev;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_hs = 1'b1; m_vs = 1'b1;
        m_ls = 1'b0; m_fs = 1'b0; m_fc = 8'd0;
    endtask

    task automatic model_advance(input logic ce);
        bit wrap;
        if (ce) begin
            // One-step delayed sync: the value shown after the edge is the raw
            // decode of the position held before the edge.
            m_hs = !(m_x >= HA + HF && m_x < HA + HF + HS);
            m_vs = !(m_y >= VA + VF && m_y < VA + VF + VS);
            wrap = (m_x == HT - 1);
            if (wrap) begin
                m_x = 0;
                m_y = (m_y == VT - 1) ? 0 : m_y + 1;
            end else begin
                m_x = m_x + 1;
            end
            m_ls = wrap;
            m_fs = wrap && (m_y == 0);
            if (m_fs) m_fc = m_fc + 8'd1;
        end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
        end
    endtask

    function automatic vec_t model_vec();
        vec_t v;
        v.x  = 10'(m_x);
        v.y  = 10'(m_y);
        v.bl = (m_x < HA) && (m_y < VA);
        v.hs = m_hs;
        v.vs = m_vs;
        v.ls = m_ls;
        v.fs = m_fs;
        v.fc = m_fc;
        return v;
    endfunction

    function automatic vec_t dut_vec();
        return {DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count};
    endfunction

    task automatic check_vec(input string tag, input vec_t got, input vec_t exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed x=%0d y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b fc=%0d expected x=%0d y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                   tag, got.x, got.y, got.bl, got.hs, got.vs, got.ls, got.fs, got.fc,
                   exp.x, exp.y, exp.bl, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_meas();
        hs_low = 0; hs_first_x = -1; vs_low = 0; vs_first_x = -1; vs_first_y = -1;
        hs_prev = hs; vs_prev = vs;
    endtask

    // One vga_clk cycle: drive at the falling edge, compare at the next one.
    task automatic step(input logic ce);
        pixel_ce = ce;
        model_advance(ce);
        sb_q.push_back(model_vec());
        @(negedge vga_clk);
        check_vec("step", dut_vec(), sb_q.pop_front());
        if (hs === 1'b0) begin
            if (hs_prev === 1'b1) hs_first_x = int'(DrawX);
            hs_low++;
        end
        if (vs === 1'b0) begin
            if (vs_prev === 1'b1) begin
                vs_first_x = int'(DrawX);
                vs_first_y = int'(DrawY);
            end
            vs_low++;
        end
        hs_prev = hs;
        vs_prev = vs;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        pixel_ce = 1'b0;
        model_reset();
        repeat (3) @(negedge vga_clk);
        check_vec("reset", dut_vec(), RESET_VEC);
        reset_n = 1'b1;
        check_vec("release", dut_vec(), RESET_VEC);

        // First two steps: DrawX 1 then 2, no pulses
        step(1'b1);
        step(1'b1);
        check_int("x_after_2", int'(DrawX), 2);

        // Rest of line 0: hs low for HS steps, first seen one step after x=HA+HF
        clear_meas();
        repeat (HT - 2) step(1'b1);
        check_int("hs_low_steps", hs_low, HS);
        check_int("hs_first_x", hs_first_x, HA + HF + 1);
        check_int("line1_y", int'(DrawY), 1);

        // Remainder of the frame: vs low for VS lines, then the frame wrap
        clear_meas();
        repeat (FT - HT) step(1'b1);
        check_int("vs_low_steps", vs_low, VS * HT);
        check_int("vs_first_x", vs_first_x, 1);
        check_int("vs_first_y", vs_first_y, VA + VF);
        check_int("wrap_pulses", int'({line_start, frame_start}), 3);
        check_int("fc_after_frame", int'(frame_count), 1);

        // pixel_ce alternating: one full line takes 2*HT cycles
        clear_meas();
        repeat (HT) begin
            step(1'b1);
            step(1'b0);
        end
        check_int("ce_hs_low_cycles", hs_low, 2 * HS);
        check_int("ce_hs_first_x", hs_first_x, HA + HF + 1);
        check_int("ce_line_y", int'(DrawY), 1);

        // Asynchronous reset in the middle of a frame at (7,4)
        repeat (3 * HT + 7) step(1'b1);
        check_int("pre_reset_xy", int'({DrawY, DrawX}), (4 << 10) | 7);
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("async_reset", dut_vec(), RESET_VEC);
        model_reset();
        @(negedge vga_clk);
        check_vec("held_reset", dut_vec(), RESET_VEC);
        reset_n = 1'b1;
        step(1'b1);
        check_int("restart_x", int'(DrawX), 1);

        // 256 frames: frame_count reaches 255 then wraps to 0
        repeat (255 * FT - 1) step(1'b1);
        check_int("fc_255", int'(frame_count), 255);
        repeat (FT) step(1'b1);
        check_int("fc_wrap", int'(frame_count), 0);
        check_int("fs_at_wrap", int'(frame_start), 1);
        step(1'b1);
        check_int("fs_one_cycle", int'(frame_start), 0);

        check_int("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
